// File: rtl/coord_uart_framer_if.sv
// Bundles the result strobe from the centroid stage and the byte trigger toward the serial port.
interface coord_uart_framer_if;
  logic        coord_valid;
  logic [10:0] coord_x;
  logic [10:0] coord_y;
  logic        found;
  logic [7:0]  tx_data;
  logic        tx_trig;
  logic        busy;
  logic        frame_drop;

  modport slave (
    input  coord_valid, coord_x, coord_y, found,
    output tx_data, tx_trig, busy, frame_drop
  );

  modport master (
    output coord_valid, coord_x, coord_y, found,
    input  tx_data, tx_trig, busy, frame_drop
  );
endinterface

// File: rtl/coord_uart_framer.sv
// Packs a ball-tracking result into a 7-byte frame and paces it into a serial port
// that has no busy flag, holding one pending result so back-to-back results survive.
module coord_uart_framer #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 9600,
  parameter int BYTE_GAP = (CLK_FREQ / UART_BPS) * 11
) (
  input  logic                 clk,
  input  logic                 rst,
  coord_uart_framer_if.slave   bus
);

  localparam int             CW       = (BYTE_GAP > 2) ? $clog2(BYTE_GAP) : 1;
  localparam logic [CW-1:0]  GAP_LAST = CW'(BYTE_GAP - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t        state_r;
  logic [2:0]    idx_r;
  logic [CW-1:0] cnt_r;
  logic [10:0]   frm_x_r;
  logic [10:0]   frm_y_r;
  logic          frm_found_r;
  logic          pend_valid_r;
  logic [10:0]   pend_x_r;
  logic [10:0]   pend_y_r;
  logic          pend_found_r;
  logic [7:0]    tx_data_r;
  logic          tx_trig_r;
  logic          busy_r;
  logic          frame_drop_r;

  function automatic logic [7:0] frame_checksum(
    input logic [7:0] b1, input logic [7:0] b2,
    input logic [7:0] b3, input logic [7:0] b4
  );
    frame_checksum = b1 ^ b2 ^ b3 ^ b4;
  endfunction

  function automatic logic [7:0] frame_byte(
    input logic [2:0] idx, input logic fnd,
    input logic [10:0] x, input logic [10:0] y
  );
    logic [7:0] b1, b2, b3, b4;
    b1 = {fnd, 4'b0000, x[10:8]};
    b2 = x[7:0];
    b3 = {5'b00000, y[10:8]};
    b4 = y[7:0];
    case (idx)
      3'd0:    frame_byte = 8'hAA;
      3'd1:    frame_byte = b1;
      3'd2:    frame_byte = b2;
      3'd3:    frame_byte = b3;
      3'd4:    frame_byte = b4;
      3'd5:    frame_byte = frame_checksum(b1, b2, b3, b4);
      3'd6:    frame_byte = 8'h55;
      default: frame_byte = 8'h00;
    endcase
  endfunction

  // Frame sequencer: launch, byte pacing, pending slot and drop detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= 3'd0;
      cnt_r        <= CNT_ZERO;
      frm_x_r      <= 11'd0;
      frm_y_r      <= 11'd0;
      frm_found_r  <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_x_r     <= 11'd0;
      pend_y_r     <= 11'd0;
      pend_found_r <= 1'b0;
      tx_data_r    <= 8'h00;
      tx_trig_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_drop_r <= 1'b0;
    end else begin
      tx_trig_r    <= 1'b0;
      frame_drop_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pend_valid_r || bus.coord_valid) begin
            state_r   <= ST_SEND;
            idx_r     <= 3'd0;
            cnt_r     <= CNT_ZERO;
            tx_trig_r <= 1'b1;
            tx_data_r <= 8'hAA;
            busy_r    <= 1'b1;
            if (pend_valid_r) begin
              frm_x_r      <= pend_x_r;
              frm_y_r      <= pend_y_r;
              frm_found_r  <= pend_found_r;
              // A result arriving while the pending one launches becomes the new pending.
              if (bus.coord_valid) begin
                pend_x_r     <= bus.coord_x;
                pend_y_r     <= bus.coord_y;
                pend_found_r <= bus.found;
              end else begin
                pend_valid_r <= 1'b0;
              end
            end else begin
              frm_x_r     <= bus.coord_x;
              frm_y_r     <= bus.coord_y;
              frm_found_r <= bus.found;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_SEND: begin
          if (bus.coord_valid) begin
            pend_x_r     <= bus.coord_x;
            pend_y_r     <= bus.coord_y;
            pend_found_r <= bus.found;
            pend_valid_r <= 1'b1;
            frame_drop_r <= pend_valid_r;
          end else begin
            pend_valid_r <= pend_valid_r;
          end
          if (cnt_r == GAP_LAST) begin
            cnt_r <= CNT_ZERO;
            if (idx_r == 3'd6) begin
              state_r <= ST_IDLE;
              idx_r   <= 3'd0;
              busy_r  <= 1'b0;
            end else begin
              idx_r     <= idx_r + 3'd1;
              tx_trig_r <= 1'b1;
              tx_data_r <= frame_byte(idx_r + 3'd1, frm_found_r, frm_x_r, frm_y_r);
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_data    = tx_data_r;
  assign bus.tx_trig    = tx_trig_r;
  assign bus.busy       = busy_r;
  assign bus.frame_drop = frame_drop_r;

endmodule
